// File: rtl/clock_enable_controller_pkg.sv
// Shared encodings and constants for the core clock-enable controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clock_enable_controller_pkg;

  // Controller states as seen on the state output
  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  // Saturation value of the issued-enable statistic
  localparam logic [31:0] CYCLE_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/clock_enable_controller_rate_divider.sv
// Rate divider: tick is high whenever the count is 0; counts 0..ratio then wraps.
// Latency: tick is combinational from the count register; clr returns count to 0 at the next edge.
// Backpressure: none; the ratio is captured at each wrap so mid-period changes wait for the next wrap.
module clock_enable_controller_rate_divider #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] ratio,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] lim;

  assign tick = (cnt == '0);

  // Counter with clear; the period limit is latched when the count leaves 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      lim <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tick) begin
        lim <= ratio;
        cnt <= (ratio == '0) ? '0 : ONE;
      end else if (cnt >= lim) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/clock_enable_controller.sv
// Run/halt/step/breakpoint controller producing the core's registered clock enable.
// Latency: command sampled at edge k changes state at k; first cpu_en high after edge k+1.
// Backpressure: none; commands are single-cycle pulses, halt > step > run when simultaneous.
module clock_enable_controller
  import clock_enable_controller_pkg::*;
#(
  parameter int PC_WIDTH    = 16,
  parameter int COUNT_WIDTH = 16,
  parameter int DIV_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_run,
  input  logic                   cmd_halt,
  input  logic                   cmd_step,
  input  logic [COUNT_WIDTH-1:0] step_count,
  input  logic [DIV_WIDTH-1:0]   div_ratio,
  input  logic                   bp_enable,
  input  logic [PC_WIDTH-1:0]    bp_addr,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic                   cpu_en,
  output logic                   halted,
  output logic [1:0]             state,
  output logic [COUNT_WIDTH-1:0] cycles_left,
  output logic [31:0]            cycle_count
);

  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] left_q, left_d;
  logic [COUNT_WIDTH-1:0] burst_len;
  logic                   skip_q, skip_d;
  logic [31:0]            cycle_cnt_q;
  logic                   idle;
  logic                   active;
  logic                   div_tick;
  logic                   would_fire;
  logic                   bp_hit;
  logic                   issue;

  assign idle      = (state_q == ST_HALT) || (state_q == ST_BREAK);
  assign active    = !idle;
  // A zero-length burst still executes one instruction
  assign burst_len = (step_count == '0) ? ONE : step_count;

  // Divider is held at 0 while stopped, so entering RUN/STEP always fires on the next edge
  clock_enable_controller_rate_divider #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_rate_divider (
    .clk   (clk),
    .reset (reset),
    .clr   (idle),
    .en    (active),
    .ratio (div_ratio),
    .tick  (div_tick)
  );

  assign would_fire = active && div_tick;
  // Breakpoint only in RUN; skip_q lets the core step off the address it stopped on
  assign bp_hit     = (state_q == ST_RUN) && would_fire && bp_enable &&
                      (pc == bp_addr) && !skip_q;
  assign issue      = would_fire && !bp_hit && !cmd_halt;

  // Next-state, burst length and breakpoint-skip decisions
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    skip_d  = skip_q;
    if (issue) begin
      skip_d = 1'b0;
    end
    if (cmd_halt) begin
      state_d = ST_HALT;
      left_d  = '0;
    end else begin
      case (state_q)
        ST_HALT, ST_BREAK: begin
          if (cmd_step) begin
            state_d = ST_STEP;
            left_d  = burst_len;
          end else if (cmd_run) begin
            state_d = ST_RUN;
          end
          if ((state_q == ST_BREAK) && (cmd_step || cmd_run)) begin
            skip_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (bp_hit) begin
            state_d = ST_BREAK;
          end
        end
        ST_STEP: begin
          if (cmd_step) begin
            left_d = burst_len;
          end else if (cmd_run) begin
            state_d = ST_RUN;
            left_d  = '0;
          end else if (issue) begin
            left_d = left_q - ONE;
            // The edge issuing the last enable also stops the burst
            if (left_q == ONE) begin
              state_d = ST_HALT;
            end
          end
        end
        default: begin
          state_d = ST_HALT;
        end
      endcase
    end
  end

  // State, burst counter, skip flag, registered enable and saturating statistic
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HALT;
      left_q      <= '0;
      skip_q      <= 1'b0;
      cpu_en      <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      skip_q  <= skip_d;
      cpu_en  <= issue;
      if (issue && (cycle_cnt_q != CYCLE_MAX)) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end
    end
  end

  assign state       = state_q;
  assign halted      = idle;
  assign cycles_left = left_q;
  assign cycle_count = cycle_cnt_q;

endmodule
